// File: rtl/univ_shift_reg_if.sv
// Purpose: bundles the mode/data/status signals of the universal shift register.
// Latency: none, wiring only.
// Backpressure: none; the register accepts a command every cycle.
interface univ_shift_reg_if #(
    parameter int WIDTH = 4
);
    localparam int CNT_W = $clog2(WIDTH);

    logic [1:0]       mode;
    logic             sin;
    logic [WIDTH-1:0] pin;
    logic [WIDTH-1:0] pout;
    logic             sout;
    logic [CNT_W-1:0] bit_cnt;
    logic             word_valid;

    // Side that issues commands and consumes the register contents
    modport master (
        output mode, sin, pin,
        input  pout, sout, bit_cnt, word_valid
    );

    // The shift register itself
    modport slave (
        input  mode, sin, pin,
        output pout, sout, bit_cnt, word_valid
    );
endinterface

// File: rtl/univ_shift_reg.sv
// Purpose: WIDTH-bit universal shift register (hold / shift right / shift left / load) with word tracking.
// Latency: one clock edge from command to pout/sout/bit_cnt/word_valid; all outputs registered.
// Backpressure: none; a new mode is taken every cycle, word_valid is a single-cycle pulse.
module univ_shift_reg #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    univ_shift_reg_if.slave   sr
);
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_SHR   = 2'b01;
    localparam logic [1:0] MODE_SHL   = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    // Terminal count: the shift that completes a word
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] pout_q, pout_d;
    logic             sout_q, sout_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic             wv_q,   wv_d;
    logic             shift_en;

    // Next-state selection: data path follows mode, counter only advances on shifts
    always_comb begin
        pout_d   = pout_q;
        sout_d   = sout_q;
        cnt_d    = cnt_q;
        wv_d     = 1'b0;
        shift_en = 1'b0;

        case (sr.mode)
            MODE_SHR: begin
                pout_d   = {sr.sin, pout_q[WIDTH-1:1]};
                sout_d   = pout_q[0];
                shift_en = 1'b1;
            end
            MODE_SHL: begin
                pout_d   = {pout_q[WIDTH-2:0], sr.sin};
                sout_d   = pout_q[WIDTH-1];
                shift_en = 1'b1;
            end
            MODE_LOAD: begin
                // A load discards any partial word, so the count restarts
                pout_d = sr.pin;
                cnt_d  = '0;
            end
            default: begin
                // MODE_HOLD: everything keeps its value, pulse drops
            end
        endcase

        // Direction is irrelevant to the count; bits are not realigned on a turn
        if (shift_en) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                wv_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State registers with synchronous reset overriding every mode
    always_ff @(posedge clk) begin
        if (rst) begin
            pout_q <= RST_VAL;
            sout_q <= 1'b0;
            cnt_q  <= '0;
            wv_q   <= 1'b0;
        end else begin
            pout_q <= pout_d;
            sout_q <= sout_d;
            cnt_q  <= cnt_d;
            wv_q   <= wv_d;
        end
    end

    assign sr.pout       = pout_q;
    assign sr.sout       = sout_q;
    assign sr.bit_cnt    = cnt_q;
    assign sr.word_valid = wv_q;
endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised universal shift register: the successor to the fixed 4-bit SIPO.
- Supports serial-in/parallel-out in either direction, parallel load, hold, and serial-out (PISO), selected each cycle by a mode input.
- Tracks shifts with a bit counter and pulses a word-valid flag when a full WIDTH-bit word has been shifted in.
- Used as the generic serial/parallel conversion stage in sequential datapaths.

Parameters:
- WIDTH, 4, register width in bits; legal values are WIDTH >= 2.
- RST_VAL, {WIDTH{1'b0}}, value loaded into pout on reset.
- CNT_W, $clog2(WIDTH), localparam; width of bit_cnt.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- mode  input  2  00 = hold, 01 = shift right, 10 = shift left, 11 = parallel load.
- sin  input  1  serial data in.
- pin  input  WIDTH  parallel data in; used only in mode 11.
- pout  output  WIDTH  registered parallel contents.
- sout  output  1  registered bit most recently shifted out.
- bit_cnt  output  CNT_W  number of shifts since the last word boundary.
- word_valid  output  1  one-cycle pulse; a complete word is present on pout.

Behaviour:
- Reset (rst=1 at a rising edge):
  - pout <= RST_VAL; sout <= 0; bit_cnt <= 0; word_valid <= 0.
  - Reset overrides every mode.
- Hold (00):
  - pout, sout and bit_cnt are unchanged.
  - word_valid <= 0.
- Shift right (01):
  - pout <= {sin, pout[WIDTH-1:1]}; sout <= pout[0].
- Shift left (10):
  - pout <= {pout[WIDTH-2:0], sin}; sout <= pout[WIDTH-1].
- Parallel load (11):
  - pout <= pin; bit_cnt <= 0; word_valid <= 0; sout unchanged.
- Counter on every shift (01 or 10):
  - If bit_cnt == WIDTH-1: bit_cnt <= 0 and word_valid <= 1.
  - Otherwise: bit_cnt <= bit_cnt + 1 and word_valid <= 0.
- Latency:
  - All outputs are registered.
  - The shifted value appears on pout one edge after the sample.
  - word_valid is high for exactly the one cycle following the WIDTH-th consecutive shift edge. In that cycle pout holds the full word.
- Direction change mid-word: the counter keeps counting shifts regardless of direction. Bits are not realigned.
- Hold mid-word: the count is preserved, and shifting resumes from that count.
- Load mid-word: the partial word is discarded, the count returns to 0, and no word_valid is produced.
- Back-to-back words: continuous shifting gives a word_valid pulse every WIDTH cycles, with no dead cycle.
- Reset mid-word: same as power-on reset; the next word needs a full WIDTH shifts.
- X/undriven sin or pin only affects data bits, never the counter or control state.

Test Plan (WIDTH=4, RST_VAL=0000):
1. Reset, then mode=01 with sin=1,0,1,0 on four edges:
   - pout = 1000, 0100, 1010, 0101.
   - bit_cnt = 1, 2, 3, 0.
   - word_valid = 1 only after the 4th edge, for one cycle.
2. From reset, mode=10 with sin=1,0,1,1:
   - pout = 0001, 0010, 0101, 1011.
   - word_valid pulses after the 4th edge.
   - sout = 0, 0, 0, 0.
3. mode=11 with pin=1100, then mode=01 with sin=0 for four edges:
   - pout = 1100, then 0110, 0011, 0001, 0000.
   - sout = 0, 0, 1, 1.
   - word_valid pulses after the 4th shift.
4. Shift two bits, hold 3 cycles, shift two more:
   - bit_cnt stays 2 during hold.
   - word_valid pulses only after the 4th shift.
   - Then a load after 2 more shifts gives bit_cnt=0 with no pulse.
5. Shift three bits, then assert rst together with mode=11 and pin=1111:
   - pout = 0000, bit_cnt = 0, sout = 0, word_valid = 0.
   - The next word needs 4 full shifts.
6. Continuous mode=01 for 12 edges with alternating sin:
   - word_valid pulses exactly after edges 4, 8 and 12.
   - pout = 0101 at each pulse.
